// File: rtl/module_uart_bus_ctrl.sv
// module_uart_bus_ctrl: UART register front-end and TX sequencer; `define UART_CTRL_OVERRUN_EN adds the sticky OVR flag
module module_uart_bus_ctrl #(
  parameter int BUSY_WAIT_MAX = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i
);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nxt;
  logic send, new_rx, tx_err, ovr;
  logic [7:0] txd, rxd;
  logic [CNT_W-1:0] cnt;
  logic ctrl_we, txd_we, timeout, done;
  assign ctrl_we = we_i && addr_i == 4'h0;
  assign txd_we = we_i && addr_i == 4'h8 && state == IDLE;
  assign tx_data_o = txd;
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  // next state, start pulse and end-of-transfer events
  always_comb begin
    state_nxt = state;
    tx_start_o = 1'b0;
    timeout = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (ctrl_we && wd_i[0]) state_nxt = START;
      START: begin
        tx_start_o = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY:
        if (tx_busy_i) state_nxt = WAIT_DONE;
        else if (cnt == CNT_W'(BUSY_WAIT_MAX - 1)) begin
          timeout = 1'b1;
          state_nxt = IDLE;
        end
      WAIT_DONE:
        if (!tx_busy_i) begin
          done = 1'b1;
          state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end
  // wait counter: cleared in START, counts idle cycles while waiting for busy
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= state == START ? '0 : (state == WAIT_BUSY && !tx_busy_i && !timeout) ? cnt + CNT_W'(1) : cnt;
  // CTRL flags: hardware set beats a simultaneous software clear
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      send <= 1'b0;
      new_rx <= 1'b0;
      tx_err <= 1'b0;
    end else begin
      send <= (state == IDLE && ctrl_we && wd_i[0]) ? 1'b1 : (timeout || done) ? 1'b0 : send;
      new_rx <= rx_valid_i ? 1'b1 : (ctrl_we && !wd_i[1]) ? 1'b0 : new_rx;
      tx_err <= timeout ? 1'b1 : (ctrl_we && !wd_i[3]) ? 1'b0 : tx_err;
    end
`ifdef UART_CTRL_OVERRUN_EN
  // overrun: a byte arrives before software consumed the previous one
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ovr <= 1'b0;
    else ovr <= (rx_valid_i && new_rx) ? 1'b1 : (ctrl_we && !wd_i[2]) ? 1'b0 : ovr;
  logic unused_wd;
  assign unused_wd = &{1'b0, wd_i[31:8]};
`else
  assign ovr = 1'b0;
  logic unused_wd;
  assign unused_wd = &{1'b0, wd_i[31:8], wd_i[2]};
`endif
  // data registers: TXD locked while a transfer is in flight, RXD always takes the newest byte
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      txd <= '0;
      rxd <= '0;
    end else begin
      txd <= txd_we ? wd_i[7:0] : txd;
      rxd <= rx_valid_i ? rx_data_i : rxd;
    end
  // read mux, side-effect free
  always_comb
    rd_o = addr_i == 4'h0 ? {28'b0, tx_err, ovr, new_rx, send} :
           addr_i == 4'h8 ? {24'b0, txd} :
           addr_i == 4'hC ? {24'b0, rxd} : 32'b0;
endmodule

// File: tb/tb_module_uart_bus_ctrl.sv
// tb_module_uart_bus_ctrl: directed self-checking bench for module_uart_bus_ctrl
module tb_module_uart_bus_ctrl;
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, busy = 1'b0, rx_valid = 1'b0;
  logic [3:0] addr = '0;
  logic [31:0] wd = '0, rd;
  logic tx_start;
  logic [7:0] tx_data, rx_data = '0;
  int tests = 0, fails = 0, n_start = 0;
  module_uart_bus_ctrl dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .addr_i(addr), .wd_i(wd), .rd_o(rd),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(busy),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (tx_start) n_start++;
`ifdef UART_CTRL_OVERRUN_EN
  localparam logic [31:0] OVR_CTRL = 32'h6;
`else
  localparam logic [31:0] OVR_CTRL = 32'h2;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_start", {31'b0, tx_start}, 0);
    rd_chk("rst_ctrl", 4'h0, 0);
    rd_chk("rst_txd", 4'h8, 0);
    rd_chk("rst_rxd", 4'hC, 0);
    wr(4'h8, 32'h1A5);
    chk("tx_data", {24'b0, tx_data}, 32'hA5);
    rd_chk("txd_rd", 4'h8, 32'hA5);
    wr(4'h4, 32'hFFFF_FFFF);
    rd_chk("res_rd", 4'h4, 0);
    wr(4'hC, 32'hFF);
    rd_chk("rxd_ro", 4'hC, 0);
    n_start = 0;
    wr(4'h0, 32'h1);
    chk("start_hi", {31'b0, tx_start}, 1);
    rd_chk("send_set", 4'h0, 1);
    @(negedge clk);
    chk("start_lo", {31'b0, tx_start}, 0);
    @(negedge clk);
    busy = 1'b1;
    wr(4'h8, 32'h33);
    wr(4'h0, 32'h1);
    rd_chk("txd_prot", 4'h8, 32'hA5);
    repeat (6) @(negedge clk);
    rd_chk("send_busy", 4'h0, 1);
    busy = 1'b0;
    rd_chk("send_last", 4'h0, 1);
    @(negedge clk);
    rd_chk("send_clr", 4'h0, 0);
    repeat (2) @(negedge clk);
    chk("one_start", n_start, 1);
    wr(4'h0, 32'h1);
    repeat (16) @(negedge clk);
    rd_chk("to_edge", 4'h0, 1);
    @(negedge clk);
    rd_chk("to_err", 4'h0, 32'h8);
    wr(4'h0, 32'h0);
    rd_chk("err_clr", 4'h0, 0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h5C;
    @(negedge clk);
    rx_valid = 1'b0;
    rd_chk("rx_byte", 4'hC, 32'h5C);
    rd_chk("rx_flag", 4'h0, 32'h2);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h77;
    we = 1'b1;
    addr = 4'h0;
    wd = 32'h0;
    @(negedge clk);
    rx_valid = 1'b0;
    we = 1'b0;
    rd_chk("rx_coll_b", 4'hC, 32'h77);
    rd_chk("rx_coll_f", 4'h0, OVR_CTRL);
    wr(4'h0, 32'h0);
    rd_chk("rx_clr", 4'h0, 0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h11;
    @(negedge clk);
    rx_data = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    rd_chk("ovr_byte", 4'hC, 32'h22);
    rd_chk("ovr_ctrl", 4'h0, OVR_CTRL);
    wr(4'h0, 32'h0);
    rd_chk("ovr_clr", 4'h0, 0);
    wr(4'h0, 32'h1);
    @(negedge clk);
    busy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_start", {31'b0, tx_start}, 0);
    rd_chk("mid_rst_ctrl", 4'h0, 0);
    rd_chk("mid_rst_txd", 4'h8, 0);
    rd_chk("mid_rst_rxd", 4'hC, 0);
    @(negedge clk);
    rst = 1'b0;
    busy = 1'b0;
    wr(4'h0, 32'h1);
    chk("post_rst_start", {31'b0, tx_start}, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/module_uart_bus_ctrl.md
Name: module_uart_bus_ctrl

Overview:
Memory-mapped register front-end and transmit sequencer for one UART core (instanced once each for UART A, B and C).
- Sits between the bus driver (write enable and read-data mux) and the serial UART core.
- Holds control, TX-data and RX-data registers.
- Runs a TX handshake FSM that starts the core, waits for completion and clears the send bit.
- Captures received bytes and flags them for software.

Parameters:
BUSY_WAIT_MAX, 16, max cycles in WAIT_BUSY for tx_busy_i to rise before timeout (>=1)
CNT_W, 5, width of the wait counter; must hold BUSY_WAIT_MAX

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
we_i  in  1  write enable from bus driver (already gated to this UART's window)
addr_i  in  4  byte offset in the 16-byte window: 0x0 CTRL, 0x4 reserved, 0x8 TXD, 0xC RXD
wd_i  in  32  write data
rd_o  out  32  read data to bus driver mux
tx_start_o  out  1  one-cycle start pulse to UART core
tx_data_o  out  8  byte to transmit (TXD[7:0])
tx_busy_i  in  1  core transmitting
rx_data_i  in  8  received byte
rx_valid_i  in  1  one-cycle pulse: rx_data_i valid

Behaviour:
- Reset (async, any time including mid-transfer): state IDLE, CTRL=0, TXD=0, RXD=0, wait counter=0, tx_start_o=0. rd_o then reads 0 at every offset.
- CTRL bits:
  - [0] SEND: SW sets, HW clears.
  - [1] NEW_RX: HW sets, SW clears.
  - [2] OVR: optional.
  - [3] TX_ERR: HW sets on timeout, SW clears.
  - [31:4] read 0.
- CTRL write:
  - wd_i[0]=1 in IDLE: SEND<=1, state<=START on the same edge.
  - wd_i[0] ignored outside IDLE.
  - Writing 0 to bits 1/2/3 clears them; writing 1 leaves them unchanged.
- TXD write: accepted only in IDLE, else ignored. Stores wd_i[7:0]; reads back zero-extended. tx_data_o=TXD[7:0] at all times.
- RXD: read-only; writes ignored. Reads {24'b0, byte}.
- Offset 0x4 and any unlisted offset: reads 0, writes ignored.
- rd_o: combinational on addr_i; no read side effects.
- FSM states:
  - IDLE: waits for the SEND write.
  - START: tx_start_o=1 for exactly this cycle; counter<=0; next WAIT_BUSY.
  - WAIT_BUSY: if tx_busy_i=1, go to WAIT_DONE. Otherwise counter++. When counter reaches BUSY_WAIT_MAX-1 without busy: SEND<=0, TX_ERR<=1, go to IDLE.
  - WAIT_DONE: when tx_busy_i=0, SEND<=0, go to IDLE.
- Latency:
  - Write at edge N: tx_start_o high during cycle N..N+1.
  - SEND reads 0 in the cycle after the edge where the FSM samples tx_busy_i=0 in WAIT_DONE.
- RX capture: rx_valid_i=1 at an edge gives RXD<=rx_data_i and NEW_RX<=1, in any FSM state. The newest byte always overwrites.
- Simultaneous events:
  - rx_valid_i with a SW write clearing NEW_RX: set wins, NEW_RX=1.
  - Timeout with a SW write clearing TX_ERR: set wins.
  - CTRL and TXD writes cannot coincide (single address).

Optional Feature:
UART_CTRL_OVERRUN_EN
- Defined: rx_valid_i while NEW_RX=1 sets OVR=1 (sticky until SW writes 0 to bit 2; set wins on collision). RXD is still overwritten.
- Undefined: no OVR storage; CTRL[2] reads 0 and writes to it are ignored.

Test Plan:
- Reset check: assert rst_i mid-WAIT_DONE → same cycle, tx_start_o=0 and reads of 0x0/0x8/0xC return 0x0; after release, state is IDLE.
- Normal TX: write TXD=0x1A5, then CTRL=0x1; core raises busy 2 cycles after start and holds it 10 cycles. Expect:
  - tx_data_o=0xA5 and TXD reads 0xA5.
  - One tx_start_o pulse the cycle after the CTRL write.
  - CTRL reads 0x1 until busy falls, then 0x0.
- Protection: during WAIT_DONE, write TXD=0x33 and CTRL=0x1 → TXD stays 0xA5, no second tx_start_o pulse.
- Timeout: tx_busy_i held 0 after start → after 16 cycles in WAIT_BUSY, CTRL reads 0x8; writing CTRL=0x0 then reads 0x0.
- RX: pulse rx_valid_i with 0x5C → RXD reads 0x5C and CTRL[1]=1. A rx_valid_i of 0x77 on the same edge as a CTRL=0x0 write gives RXD=0x77 and CTRL[1]=1.
- Overrun (macro on): two rx pulses 0x11, 0x22 without clearing → RXD=0x22, CTRL=0x6. With the macro off, same stimulus gives CTRL=0x2.
